hex_display_scanner: RTL and testbench

HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

---
 rtl/display_pkg.sv | 13 +
 rtl/hex_to_7seg.sv | 34 +++
 rtl/hex_display_scanner.sv | 134 +++++++++++++
 tb/tb_hex_display_scanner.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed hex display scanner.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package display_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] hex_t;

  localparam seg_t        SEG_BLANK  = 7'h7F;
  localparam int          MAX_DIGITS = 16;
  // Wide enough for the largest legal digit count; users slice it down.
  localparam logic [15:0] AN_OFF     = 16'hFFFF;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Output bit order is {g,f,e,d,c,b,a}.
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  // Hex-to-segment lookup; lower-case b and d keep them distinct from 8 and 0.
  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed scanner for a common-anode hex display. The image shown is
// a per-frame snapshot so that a value changing mid-scan never tears.
module hex_display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 100000
)
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic                    load_now,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]        IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0]   AN_ALL_OFF = AN_OFF[NUM_DIGITS-1:0];
  localparam logic [NUM_DIGITS-1:0]   AN_ONE     = NUM_DIGITS'(1);
  localparam logic [4*NUM_DIGITS-1:0] VAL_ZERO   = {(4*NUM_DIGITS){1'b0}};

  if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_num_digits
    $error("hex_display_scanner: NUM_DIGITS must be in 2..16");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("hex_display_scanner: CLK_DIV must be at least 2");
  end

  logic [CNT_W-1:0]        cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic [4*NUM_DIGITS-1:0] snap_val_r;
  logic [NUM_DIGITS-1:0]   snap_dp_r;
  logic [NUM_DIGITS-1:0]   an_r;
  seg_t                    seg_r;
  logic                    dp_r;
  logic                    frame_start_r;

  logic                    tick_s;
  logic                    wrap_s;
  logic [4*NUM_DIGITS-1:0] upper_s;
  hex_t                    cur_hex_s;
  seg_t                    dec_seg_s;
  logic                    lead_blank_s;
  logic                    lit_s;
  logic [NUM_DIGITS-1:0]   an_nxt_s;
  seg_t                    seg_nxt_s;
  logic                    dp_nxt_s;

  assign tick_s = (cnt_r == CNT_LAST);
  assign wrap_s = tick_s && (idx_r == IDX_LAST);

  // Prescaler and digit index advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= {IDX_W{1'b0}};
    end else begin
      cnt_r <= tick_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
      if (tick_s) begin
        idx_r <= wrap_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
      end
    end
  end

  // Snapshot capture: frame wrap or forced load, a single capture if both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_val_r    <= VAL_ZERO;
      snap_dp_r     <= {NUM_DIGITS{1'b0}};
      frame_start_r <= 1'b0;
    end else begin
      if (wrap_s || load_now) begin
        snap_val_r <= value;
        snap_dp_r  <= dp_in;
      end
      frame_start_r <= wrap_s;
    end
  end

  // Nibbles from the selected digit upward; all zero means a leading zero.
  assign upper_s   = snap_val_r >> {idx_r, 2'b00};
  assign cur_hex_s = upper_s[3:0];

  hex_to_7seg u_dec (
    .hex (cur_hex_s),
    .seg (dec_seg_s)
  );

  // Next output image for the selected digit; dark unless enabled and not lead-blanked.
  always_comb begin
    lead_blank_s = blank_lz && (idx_r != {IDX_W{1'b0}}) && (upper_s == VAL_ZERO);
    lit_s        = digit_en[idx_r] && !lead_blank_s;
    an_nxt_s     = AN_ALL_OFF;
    seg_nxt_s    = SEG_BLANK;
    dp_nxt_s     = 1'b1;
    if (lit_s) begin
      an_nxt_s  = ~(AN_ONE << idx_r);
      seg_nxt_s = dec_seg_s;
      dp_nxt_s  = ~snap_dp_r[idx_r];
    end else begin
      an_nxt_s  = AN_ALL_OFF;
      seg_nxt_s = SEG_BLANK;
      dp_nxt_s  = 1'b1;
    end
  end

  // Registered display drive, refreshed every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_r  <= AN_ALL_OFF;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_nxt_s;
      seg_r <= seg_nxt_s;
      dp_r  <= dp_nxt_s;
    end
  end

  assign an          = an_r;
  assign seg         = seg_r;
  assign dp          = dp_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed self-checking bench for hex_display_scanner with 4 digits and a
// 4-cycle digit slot; outputs are sampled 1 ns after each rising edge.
module tb_hex_display_scanner;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic        load_now;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_checks;
  int n_fail;

  hex_display_scanner #(.NUM_DIGITS(4), .CLK_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .blank_lz    (blank_lz),
    .load_now    (load_now),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frame_start;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (frame_start === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_frame_start: frame_start=0, required 1 within 64 cycles");
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; value = 16'h12AF; dp_in = 4'b0000; digit_en = 4'b1111;
    blank_lz = 1'b0; load_now = 1'b0;
    step(3);
    n_checks++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: an=%b seg=%b dp=%b fs=%b, required 1111 1111111 1 0", an, seg, dp, frame_start);
    end
    reset = 1'b0;
    step(1);
    n_checks++;
    if (an !== 4'b1110 || seg !== 7'h40 || dp !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_update: an=%b seg=%b dp=%b, required 1110 1000000 1", an, seg, dp);
    end
    step(3);
    n_checks++;
    if (an !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_slot0_hold: an=%b, required 1110", an);
    end
    step(1);
    n_checks++;
    if (an !== 4'b1101) begin
      n_fail++;
      $display("FAIL reset_first_tick: an=%b, required 1101", an);
    end
  endtask

  task automatic test_walk;
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    int d;
    exp_seg = '{7'h0E, 7'h08, 7'h24, 7'h79};
    wait_frame_start();
    for (int c = 0; c < 16; c++) begin
      d = c / 4;
      step(1);
      exp_an = 4'b0001 << d;
      exp_an = ~exp_an;
      n_checks++;
      if (an !== exp_an || seg !== exp_seg[d] || dp !== 1'b1) begin
        n_fail++;
        $display("FAIL walk c=%0d: an=%b seg=%b dp=%b, required %b %b 1", c, an, seg, dp, exp_an, exp_seg[d]);
      end
    end
  endtask

  task automatic test_blank_lz;
    blank_lz = 1'b1;
    value = 16'h0005;
    wait_frame_start();
    for (int c = 0; c < 16; c++) begin
      step(1);
      n_checks++;
      if (c < 4) begin
        if (an !== 4'b1110 || seg !== 7'h12) begin
          n_fail++;
          $display("FAIL blank_0005 c=%0d: an=%b seg=%b, required 1110 0010010", c, an, seg);
        end
      end else begin
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
          n_fail++;
          $display("FAIL blank_0005 c=%0d: an=%b seg=%b dp=%b, required 1111 1111111 1", c, an, seg, dp);
        end
      end
    end
    value = 16'h0000;
    wait_frame_start();
    for (int c = 0; c < 16; c++) begin
      step(1);
      n_checks++;
      if (c < 4) begin
        if (an !== 4'b1110 || seg !== 7'h40) begin
          n_fail++;
          $display("FAIL blank_0000 c=%0d: an=%b seg=%b, required 1110 1000000", c, an, seg);
        end
      end else begin
        if (an !== 4'b1111 || seg !== 7'h7F) begin
          n_fail++;
          $display("FAIL blank_0000 c=%0d: an=%b seg=%b, required 1111 1111111", c, an, seg);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_no_tear;
    value = 16'h1111;
    wait_frame_start();
    for (int c = 0; c < 16; c++) begin
      step(1);
      n_checks++;
      if (seg !== 7'h79) begin
        n_fail++;
        $display("FAIL no_tear_old c=%0d: seg=%b, required 1111001", c, seg);
      end
      if (c == 5) value = 16'h2222;
    end
    n_checks++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL no_tear_frame_start: frame_start=%b, required 1", frame_start);
    end
    step(1);
    n_checks++;
    if (an !== 4'b1110 || seg !== 7'h24) begin
      n_fail++;
      $display("FAIL no_tear_new: an=%b seg=%b, required 1110 0100100", an, seg);
    end
    step(15);
  endtask

  task automatic test_load_now;
    // Entered on the wrap edge: digit 1 is on display six cycles later.
    step(6);
    value = 16'h3333;
    load_now = 1'b1;
    step(1);
    load_now = 1'b0;
    step(1);
    n_checks++;
    if (an !== 4'b1101 || seg !== 7'h30) begin
      n_fail++;
      $display("FAIL load_now_update: an=%b seg=%b, required 1101 0110000", an, seg);
    end
    step(1);
    n_checks++;
    if (an !== 4'b1011 || seg !== 7'h30) begin
      n_fail++;
      $display("FAIL load_now_timing: an=%b seg=%b, required 1011 0110000", an, seg);
    end
    step(7);
    n_checks++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL load_now_frame: frame_start=%b, required 1", frame_start);
    end
  endtask

  task automatic test_enable_dp;
    logic [3:0] exp_an;
    int d;
    digit_en = 4'b1011;
    dp_in = 4'b0001;
    wait_frame_start();
    for (int c = 0; c < 16; c++) begin
      d = c / 4;
      step(1);
      n_checks++;
      if (d == 2) begin
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
          n_fail++;
          $display("FAIL enable_dark c=%0d: an=%b seg=%b dp=%b, required 1111 1111111 1", c, an, seg, dp);
        end
      end else begin
        exp_an = 4'b0001 << d;
        exp_an = ~exp_an;
        if (an !== exp_an || seg !== 7'h30 || dp !== (d != 0)) begin
          n_fail++;
          $display("FAIL enable_dp c=%0d: an=%b seg=%b dp=%b, required %b 0110000 %b", c, an, seg, dp, exp_an, (d != 0));
        end
      end
    end
    digit_en = 4'b1111;
    dp_in = 4'b0000;
  endtask

  task automatic test_async_reset;
    step(6);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: an=%b seg=%b dp=%b fs=%b, required 1111 1111111 1 0", an, seg, dp, frame_start);
    end
    step(2);
    reset = 1'b0;
    step(1);
    n_checks++;
    if (an !== 4'b1110 || seg !== 7'h40) begin
      n_fail++;
      $display("FAIL async_restart: an=%b seg=%b, required 1110 1000000", an, seg);
    end
    step(4);
    n_checks++;
    if (an !== 4'b1101) begin
      n_fail++;
      $display("FAIL async_restart_tick: an=%b, required 1101", an);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_walk();
    test_blank_lz();
    test_no_tear();
    test_load_now();
    test_enable_dp();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
